branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 9, which is the width of all PC ports.
REQ-002 SHALL have parameter ENTRIES, default 16, which is the table depth; it is a power of two, 2..256.
REQ-003 SHALL have parameter CTR_WIDTH, default 2, which is the width of each saturating counter, 1..4.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port halt, input, 1 bit: freezes all state while high.
REQ-007 SHALL have port flush, input, 1 bit: invalidates all entries.
REQ-008 SHALL have port lookup_pc, input, PC_WIDTH bits: the fetch PC.
REQ-009 SHALL have port pred_hit, output, 1 bit: a valid entry with matching tag exists for lookup_pc.
REQ-010 SHALL have port pred_taken, output, 1 bit: predicted taken, equal to pred_hit AND counter MSB.
REQ-011 SHALL have port pred_target, output, 32 bits: the stored target when pred_taken, else zero-extended lookup_pc+4.
REQ-012 SHALL have resolve ports resolve_valid (input, 1 bit), resolve_pc (input, PC_WIDTH bits), resolve_taken (input, 1 bit), resolve_is_jump (input, 1 bit), resolve_target (input, 32 bits), resolve_pred_taken (input, 1 bit) and resolve_pred_target (input, 32 bits), driven from the execute stage.
REQ-013 SHALL have port mispredict, output, 1 bit: a registered redirect request.
REQ-014 SHALL have port redirect_pc, output, 32 bits: the registered correct next PC.
REQ-015 SHALL have ports stat_lookups and stat_mispredicts, output, 32 bits each, present only with BPU_STATS_EN.

Function
REQ-016 SHALL derive index = PC[IDXW+1:2] with IDXW = log2(ENTRIES), and tag = PC[PC_WIDTH-1:IDXW+2].
REQ-017 SHALL compute the lookup combinationally from registered table state, with no bypass of a same-cycle update.
REQ-018 SHALL, on resolve_valid with halt low, update the table entry at resolve_pc's index on the next clock edge.
REQ-019 SHALL, on a hit for the update: taken increments the counter, saturating at 2^CTR_WIDTH-1; not-taken decrements it, saturating at 0; a taken result rewrites the target.
REQ-020 SHALL, on a miss for the update with resolve_taken high: allocate the entry (set valid, tag and target), with the counter set to 2^(CTR_WIDTH-1), i.e. weakly taken.
REQ-021 SHALL, on a miss for the update with resolve_taken low: leave the table unchanged.
REQ-022 SHALL, when resolve_is_jump is high, force the counter to 2^CTR_WIDTH-1 regardless of its prior value.
REQ-023 SHALL, one cycle after resolve_valid with halt low, set mispredict = (resolve_taken != resolve_pred_taken) OR (resolve_taken AND resolve_target != resolve_pred_target).
REQ-024 SHALL register redirect_pc in the same cycle as mispredict: resolve_target if taken, else zero-extended resolve_pc+4.
REQ-025 SHALL hold mispredict high for exactly one cycle per event and hold redirect_pc at its last value otherwise.
REQ-026 SHALL make flush clear every valid bit on the next edge; flush with resolve_valid in the same cycle gives flush priority for the table (no allocation), while mispredict/redirect_pc are still produced.
REQ-027 SHALL, while halt is high, hold table, mispredict (forced 0) and redirect_pc; resolve inputs are ignored and not queued.
REQ-028 SHALL perform all PC arithmetic in 32 bits with PC zero-extended, and let +4 overflow wrap modulo 2^32.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear all valid bits, counters, tags, targets, mispredict and redirect_pc to 0, and statistics counters to 0.
REQ-030 SHALL cancel any pending mispredict when rst_n is asserted mid-operation; the first update is accepted on the first edge after rst_n rises.

Configuration
REQ-031 SHALL, with BPU_STATS_EN defined: increment stat_lookups each non-halt cycle, and stat_mispredicts each cycle mispredict is set; both wrap at 2^32 and are not cleared by flush.
REQ-032 SHALL, without BPU_STATS_EN: omit the stat ports and counters entirely, with all other behaviour identical.

Verification
REQ-033 SHALL cover: after reset, lookup_pc=0x010 -> pred_hit=0, pred_taken=0, pred_target=0x14.
REQ-034 SHALL cover: resolve pc=0x010, taken, target=0x040, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x40; then lookup 0x010 -> hit, taken, target 0x40.
REQ-035 SHALL cover: three not-taken resolves at 0x010 -> counter 2→1→0→0 (saturates at 0), pred_taken=0 after the first, mispredict=1 only on the first.
REQ-036 SHALL cover: 0x010 and 0x050 (same index, different tag) -> 0x050 allocation evicts 0x010, and lookup 0x010 misses.
REQ-037 SHALL cover: flush and resolve taken at 0x020 in the same cycle -> no entry allocated, mispredict still asserted next cycle.
REQ-038 SHALL cover: halt high during resolve -> no table change, mispredict=0; rst_n low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction
// and a registered mispredict/redirect path. Define BPU_STATS_EN to add lookup/mispredict statistics.
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH  = 9,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  input  logic                resolve_valid,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  input  logic                resolve_taken,
  input  logic                resolve_is_jump,
  input  logic [31:0]         resolve_target,
  input  logic                resolve_pred_taken,
  input  logic [31:0]         resolve_pred_target,
  output logic                mispredict,
  output logic [31:0]         redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = PC_WIDTH - IDXW - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

  logic [ENTRIES-1:0]   valid_q;
  logic [TAGW-1:0]      tag_q [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
  logic [31:0]          tgt_q [ENTRIES];

  logic [IDXW-1:0]      l_idx;
  logic [TAGW-1:0]      l_tag;
  logic [IDXW-1:0]      r_idx;
  logic [TAGW-1:0]      r_tag;
  logic                 r_hit;
  logic                 upd_en;
  logic [CTR_WIDTH-1:0] upd_ctr;
  logic [31:0]          upd_tgt;
  logic                 wr_en;
  logic                 mis_c;
  logic [31:0]          redir_c;

  // Lookup reads only registered table state; same-cycle updates are not bypassed.
  assign l_idx       = lookup_pc[IDXW+1:2];
  assign l_tag       = lookup_pc[PC_WIDTH-1:IDXW+2];
  assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit && ctr_q[l_idx][CTR_WIDTH-1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : (32'(lookup_pc) + 32'd4);

  assign r_idx = resolve_pc[IDXW+1:2];
  assign r_tag = resolve_pc[PC_WIDTH-1:IDXW+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  // Next contents of the resolved entry; a not-taken miss leaves the table alone.
  always_comb begin
    upd_en  = 1'b0;
    upd_ctr = ctr_q[r_idx];
    upd_tgt = tgt_q[r_idx];
    if (r_hit) begin
      upd_en = 1'b1;
      if (resolve_taken) begin
        upd_tgt = resolve_target;
        if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + CTR_WIDTH'(1);
      end else if (upd_ctr != '0) begin
        upd_ctr = upd_ctr - CTR_WIDTH'(1);
      end
    end else if (resolve_taken) begin
      upd_en  = 1'b1;
      upd_ctr = CTR_WEAK;
      upd_tgt = resolve_target;
    end
    if (resolve_is_jump) upd_ctr = CTR_MAX;
  end

  assign wr_en   = resolve_valid && !halt && !flush && upd_en;
  assign mis_c   = (resolve_taken != resolve_pred_taken) ||
                   (resolve_taken && (resolve_target != resolve_pred_target));
  assign redir_c = resolve_taken ? resolve_target : (32'(resolve_pc) + 32'd4);

  // Table state; flush wins over a same-cycle allocation or update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (!halt) begin
      if (flush) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
        ctr_q[r_idx]   <= upd_ctr;
        tgt_q[r_idx]   <= upd_tgt;
      end
    end
  end

  // One-cycle redirect pulse; redirect_pc only moves on a mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (halt) begin
      mispredict  <= 1'b0;
    end else begin
      mispredict <= resolve_valid && mis_c;
      if (resolve_valid && mis_c) redirect_pc <= redir_c;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else if (!halt) begin
      stat_lookups <= stat_lookups + 32'd1;
      if (resolve_valid && mis_c) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
